e_mdu: RTL and testbench
========================

# e_mdu

Multi-cycle multiply/divide unit in the E stage. Executes `mult`, `multu`, `div`, `divu`, `mthi`, `mtlo`, `mfhi` and `mflo` against private HI/LO registers. It is the responder side of a start/busy handshake whose initiator is the E-stage control path plus SU. SU stalls D while `start | busy` and D holds an MD instruction.

## Interface
Parameters:
- MULT_CYCLES, 5, busy length for mult/multu
- DIV_CYCLES, 10, busy length for div/divu

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high; clears all state
- start  in  1  one-cycle pulse; accompanies a mult/multu/div/divu op
- op  in  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO
- A  in  32  forwarded rs value
- B  in  32  forwarded rt value
- busy  out  1  operation in flight
- hi  out  32  HI register
- lo  out  32  LO register
- out  32  out  read data: hi when op=MFHI, lo when op=MFLO, else 0 (combinational)

## Operation
- State: HI, LO, count (4 bits), result_hi/result_lo holding registers, pending-op register.
- Reset: HI=0, LO=0, count=0, busy=0, out=0.
- IDLE (count=0):
  - start with op in 1..4: capture A/B and compute the 64-bit result into result_hi/result_lo. Load count with MULT_CYCLES or DIV_CYCLES.
  - op=MTHI writes HI=A. op=MTLO writes LO=A. Both take effect on the same edge and never assert busy.
- BUSY (count≠0):
  - Decrement count each edge.
  - On the 1→0 edge, commit HI/LO from the holding registers.
- Arithmetic:
  - MULT: {HI,LO} = signed A × signed B.
  - MULTU: {HI,LO} = unsigned A × unsigned B.
  - DIV: LO = quotient truncated toward zero; HI = remainder, carrying the sign of the dividend.
  - DIVU: unsigned quotient in LO, remainder in HI.
  - Overflow case 0x80000000 / −1 gives LO=0x80000000, HI=0.
- Illegal or overlapping requests are ignored:
  - start while busy is ignored; HI/LO and count are unaffected.
  - MTHI/MTLO while busy are ignored. SU never issues either case.
- MFHI/MFLO while busy return the pre-operation HI/LO. SU must stall them.
- start with op outside 1..4 is ignored.

## Timing
- start sampled at edge T0.
- busy is high for cycles T0+1 … T0+N, where N is MULT_CYCLES or DIV_CYCLES.
- New HI/LO are visible from T0+N+1, the same cycle busy drops.
- A new start is accepted at T0+N+1.
- MTHI/MTLO: the write is visible the cycle after the edge.
- out has zero latency relative to op and the HI/LO registers.
- reset mid-operation: the in-flight result is discarded; count=0, HI/LO=0 next cycle.

## Configuration
- `MDU_DIV0_HOLD_EN` defined:
  - div/divu with B=0 runs the full DIV_CYCLES busy period.
  - It commits nothing; HI/LO are unchanged.
- Undefined:
  - div/divu with B=0 commits LO=0xFFFFFFFF and HI=A.
  - Both results are deterministic; no X propagation.

## Structure
- Shared Define header holds:
  - op encodings (MDU_NONE … MDU_MFLO)
  - default MULT/DIV cycle counts
  - the MD-instruction decode used by CU and SU for stall generation
- No sub-module in the base version. The divide-by-zero/overflow selection may sit in a small combinational function inside e_mdu.

## Test plan
- MULT A=0xFFFFFFFD (−3), B=5 → busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- MULTU A=0xFFFFFFFF, B=2 → HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles.
- DIV A=−7, B=2 → 10 busy cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU A=7, B=2 → LO=3, HI=1.
- DIV B=0, HI=0x11, LO=0x22 beforehand:
  - with `MDU_DIV0_HOLD_EN` → HI=0x11, LO=0x22;
  - without → LO=0xFFFFFFFF, HI=A.
- MTHI 0xABCD while busy, then second start during busy → both ignored; HI = multiply result.
- MFLO after busy drops → out = LO.
- reset at 3rd busy cycle → busy=0, HI=LO=0 next cycle.

Source files
------------

// File: rtl/e_mdu_pkg.sv
// e_mdu_pkg: shared definitions for the E-stage multiply/divide unit.
// Holds the MD op encodings, default busy lengths and the MD-instruction
// decode that the control path and stall unit use to detect MD ops in D.
package e_mdu_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned CNT_W  = 4;

  localparam int unsigned MDU_MULT_CYCLES_DEF = 5;
  localparam int unsigned MDU_DIV_CYCLES_DEF  = 10;

  typedef enum logic [OP_W-1:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MTHI  = 4'd5,
    MDU_MTLO  = 4'd6,
    MDU_MFHI  = 4'd7,
    MDU_MFLO  = 4'd8
  } mdu_op_e;

  // Any instruction that touches HI/LO; used for stall generation.
  function automatic logic is_md_op(input logic [OP_W-1:0] op);
    return (op >= OP_W'(MDU_MULT)) && (op <= OP_W'(MDU_MFLO));
  endfunction

  // Ops that launch a multi-cycle operation when accompanied by start.
  function automatic logic is_start_op(input logic [OP_W-1:0] op);
    return (op >= OP_W'(MDU_MULT)) && (op <= OP_W'(MDU_DIVU));
  endfunction

endpackage

// File: rtl/e_mdu.sv
// e_mdu: multi-cycle multiply/divide unit with private HI/LO registers.
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   start, op       one-cycle launch pulse and MD op encoding
//   A, B            forwarded rs/rt operands
//   busy            operation in flight
//   hi, lo          HI/LO register contents
//   out             combinational read data for MFHI/MFLO, else 0
// Config macro: MDU_DIV0_HOLD_EN -- when defined, divide by zero runs the
// full busy period but commits nothing; otherwise it commits LO=all-ones,
// HI=dividend.
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MDU_MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [OP_W-1:0]     op,
  input  logic [DATA_W-1:0]   A,
  input  logic [DATA_W-1:0]   B,
  output logic                busy,
  output logic [DATA_W-1:0]   hi,
  output logic [DATA_W-1:0]   lo,
  output logic [DATA_W-1:0]   out
);

  logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [DATA_W-1:0] res_hi_q, res_hi_d, res_lo_q, res_lo_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              busy_q, busy_d;
  logic              commit_q, commit_d;

  // Divide result selection: {HI, LO}; zero divisor yields a fixed pattern.
  function automatic logic [2*DATA_W-1:0] div_select(
    input logic              div0,
    input logic [DATA_W-1:0] quo,
    input logic [DATA_W-1:0] rem,
    input logic [DATA_W-1:0] dividend
  );
    if (div0) return {dividend, {DATA_W{1'b1}}};
    return {rem, quo};
  endfunction

  // Arithmetic datapath, evaluated on the launch cycle only.
  logic [2*DATA_W-1:0] prod_s_c, prod_u_c, res_c;
  logic [DATA_W-1:0]   a_mag_c, b_mag_c, b_sdiv_c, b_udiv_c;
  logic [DATA_W-1:0]   q_mag_c, r_mag_c, q_s_c, r_s_c, q_u_c, r_u_c;
  logic                div0_c, commit_c;
  logic [CNT_W-1:0]    cycles_c;

  always_comb begin
    // Low 64 bits of the sign-extended product equal the signed product.
    prod_s_c = {{DATA_W{A[DATA_W-1]}}, A} * {{DATA_W{B[DATA_W-1]}}, B};
    prod_u_c = {{DATA_W{1'b0}}, A} * {{DATA_W{1'b0}}, B};

    div0_c   = (B == '0);
    // Signed divide via magnitudes; 0x80000000 / -1 falls out as 0x80000000 r 0.
    a_mag_c  = A[DATA_W-1] ? DATA_W'(-A) : A;
    b_mag_c  = B[DATA_W-1] ? DATA_W'(-B) : B;
    b_sdiv_c = div0_c ? DATA_W'(1) : b_mag_c;
    b_udiv_c = div0_c ? DATA_W'(1) : B;
    q_mag_c  = a_mag_c / b_sdiv_c;
    r_mag_c  = a_mag_c % b_sdiv_c;
    q_s_c    = (A[DATA_W-1] ^ B[DATA_W-1]) ? DATA_W'(-q_mag_c) : q_mag_c;
    r_s_c    = A[DATA_W-1] ? DATA_W'(-r_mag_c) : r_mag_c;
    q_u_c    = A / b_udiv_c;
    r_u_c    = A % b_udiv_c;

    res_c    = '0;
    cycles_c = CNT_W'(MULT_CYCLES);
    commit_c = 1'b1;
    case (op)
      MDU_MULT:  res_c = prod_s_c;
      MDU_MULTU: res_c = prod_u_c;
      MDU_DIV: begin
        res_c    = div_select(div0_c, q_s_c, r_s_c, A);
        cycles_c = CNT_W'(DIV_CYCLES);
      end
      MDU_DIVU: begin
        res_c    = div_select(div0_c, q_u_c, r_u_c, A);
        cycles_c = CNT_W'(DIV_CYCLES);
      end
      default: ;
    endcase
`ifdef MDU_DIV0_HOLD_EN
    if (div0_c && ((op == MDU_DIV) || (op == MDU_DIVU))) commit_c = 1'b0;
`endif
  end

  // Next-state: launch / MTHI / MTLO in idle, countdown and commit when busy.
  always_comb begin
    hi_d     = hi_q;
    lo_d     = lo_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    count_d  = count_q;
    busy_d   = busy_q;
    commit_d = commit_q;
    if (count_q == '0) begin
      if (start && is_start_op(op)) begin
        res_hi_d = res_c[2*DATA_W-1:DATA_W];
        res_lo_d = res_c[DATA_W-1:0];
        count_d  = cycles_c;
        busy_d   = 1'b1;
        commit_d = commit_c;
      end else if (op == MDU_MTHI) begin
        hi_d = A;
      end else if (op == MDU_MTLO) begin
        lo_d = A;
      end
    end else begin
      count_d = count_q - CNT_W'(1);
      if (count_q == CNT_W'(1)) begin
        busy_d = 1'b0;
        if (commit_q) begin
          hi_d = res_hi_q;
          lo_d = res_lo_q;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q     <= '0;
      lo_q     <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      count_q  <= '0;
      busy_q   <= 1'b0;
      commit_q <= 1'b0;
    end else begin
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
      commit_q <= commit_d;
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
  // Zero-latency read port.
  assign out  = (op == MDU_MFHI) ? hi_q :
                (op == MDU_MFLO) ? lo_q : '0;

endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: directed plus randomized checks of e_mdu against an arithmetic
// reference model of HI/LO.
module tb_e_mdu;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  op = OP_NONE;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        busy;
  logic [31:0] hi, lo, out;

  int checks = 0;
  int failures = 0;
  logic [31:0] tb_hi = '0;
  logic [31:0] tb_lo = '0;

  e_mdu dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo),
    .out   (out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: new {HI,LO} from plain 64-bit arithmetic on the operands.
  function automatic void model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] ohi, input logic [31:0] olo,
                                output logic [31:0] nhi, output logic [31:0] nlo);
    longint sp, sq, sr;
    longint unsigned up;
    nhi = ohi;
    nlo = olo;
    case (o)
      OP_MULT: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        nhi = sp[63:32]; nlo = sp[31:0];
      end
      OP_MULTU: begin
        up = 64'(a) * 64'(b);
        nhi = up[63:32]; nlo = up[31:0];
      end
      OP_DIV, OP_DIVU: begin
        if (b == 0) begin
`ifndef MDU_DIV0_HOLD_EN
          nhi = a; nlo = 32'hFFFF_FFFF;
`endif
        end else if (o == OP_DIV) begin
          sq = longint'($signed(a)) / longint'($signed(b));
          sr = longint'($signed(a)) % longint'($signed(b));
          nlo = sq[31:0]; nhi = sr[31:0];
        end else begin
          nlo = a / b; nhi = a % b;
        end
      end
      default: ;
    endcase
  endfunction

  // Launch an MD op, count busy cycles (bounded), then check HI/LO.
  task automatic run_md(input string tag, input logic [3:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    int n = 0;
    int nexp = (o == OP_MULT || o == OP_MULTU) ? 5 : 10;
    @(negedge clk); start = 1'b1; op = o; A = a; B = b;
    @(negedge clk); start = 1'b0; op = OP_NONE; A = $urandom; B = $urandom;
    while (busy === 1'b1 && n < 20) begin
      n++;
      if (n == 2) begin
        op = OP_MFHI; #1;
        chk({tag, "_mfhi_busy"}, out, tb_hi);
        op = OP_NONE;
      end
      @(negedge clk);
    end
    chk({tag, "_cycles"}, 32'(n), 32'(nexp));
    chk({tag, "_hi"}, hi, ehi);
    chk({tag, "_lo"}, lo, elo);
    tb_hi = ehi;
    tb_lo = elo;
  endtask

  task automatic run_rand_md(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ehi, elo;
    model(o, a, b, tb_hi, tb_lo, ehi, elo);
    run_md("rnd_md", o, a, b, ehi, elo);
  endtask

  task automatic do_mt(input string tag, input logic [3:0] o, input logic [31:0] a);
    @(negedge clk); op = o; A = a;
    @(negedge clk); op = OP_NONE;
    if (o == OP_MTHI) tb_hi = a; else tb_lo = a;
    chk({tag, "_hi"}, hi, tb_hi);
    chk({tag, "_lo"}, lo, tb_lo);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic do_mf(input string tag, input logic [3:0] o);
    op = o; #1;
    chk(tag, out, (o == OP_MFHI) ? tb_hi : tb_lo);
    op = OP_NONE; #1;
    chk({tag, "_none"}, out, 32'd0);
  endtask

  initial begin
    int n;
    logic [3:0] ro;
    logic [31:0] ra, rb;

    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_out", out, 32'd0);

    run_md("mult", OP_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_md("multu", OP_MULTU, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE);
    do_mf("mflo_after", OP_MFLO);
    run_md("div", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_md("divu", OP_DIVU, 32'd7, 32'd2, 32'd1, 32'd3);
    run_md("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);

    do_mt("mthi", OP_MTHI, 32'h11);
    do_mt("mtlo", OP_MTLO, 32'h22);
`ifdef MDU_DIV0_HOLD_EN
    run_md("div0", OP_DIV, 32'h1234_5678, 32'd0, 32'h11, 32'h22);
    run_md("divu0", OP_DIVU, 32'h0BAD_F00D, 32'd0, 32'h11, 32'h22);
`else
    run_md("div0", OP_DIV, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF);
    run_md("divu0", OP_DIVU, 32'h0BAD_F00D, 32'd0, 32'h0BAD_F00D, 32'hFFFF_FFFF);
`endif

    // Overlap: MTHI and a second start while busy must both be ignored.
    @(negedge clk); start = 1'b1; op = OP_MULT; A = 32'd3; B = 32'd4;
    @(negedge clk); start = 1'b0; op = OP_NONE;
    n = 0;
    while (busy === 1'b1 && n < 20) begin
      n++;
      case (n)
        1: begin op = OP_MTHI; A = 32'hABCD; end
        2: begin start = 1'b1; op = OP_MULT; A = 32'd100; B = 32'd100; end
        3: begin start = 1'b0; op = OP_NONE; end
        default: ;
      endcase
      @(negedge clk);
    end
    start = 1'b0; op = OP_NONE;
    chk("ovl_cycles", 32'(n), 32'd5);
    chk("ovl_hi", hi, 32'd0);
    chk("ovl_lo", lo, 32'd12);
    tb_hi = 32'd0; tb_lo = 32'd12;

    // Reset in the third busy cycle discards the in-flight result.
    do_mt("pre_rst", OP_MTHI, 32'h5555_AAAA);
    @(negedge clk); start = 1'b1; op = OP_MULT; A = 32'd5; B = 32'd6;
    @(negedge clk); start = 1'b0; op = OP_NONE;
    n = 0;
    while (busy === 1'b1 && n < 3) begin
      n++;
      if (n < 3) @(negedge clk);
    end
    chk("rst_mid_seen", 32'(n), 32'd3);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_hi", hi, 32'd0);
    chk("rst_mid_lo", lo, 32'd0);
    tb_hi = '0; tb_lo = '0;
    @(negedge clk);
    chk("rst_mid_hold_busy", 32'(busy), 32'd0);

    // Random mix of all ops against the reference model.
    for (int i = 0; i < 60; i++) begin
      ro = 4'($urandom_range(1, 8));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = 32'($urandom_range(0, 7));
        1: rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
      case (ro)
        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: run_rand_md(ro, ra, rb);
        OP_MTHI, OP_MTLO: do_mt("rnd_mt", ro, ra);
        default: begin
          @(negedge clk);
          do_mf("rnd_mf", ro);
        end
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
